fft_bitrev_reorder: RTL

//  Sits directly downstream of fft_3 and converts its bit-reversed output stream into

---
 rtl/fft_bitrev_reorder_pkg.sv | 17 +
 rtl/fft_bitrev_reorder_ram.sv | 34 +++
 rtl/fft_bitrev_reorder.sv | 106 ++++++++++
 3 files changed

// File: rtl/fft_bitrev_reorder_pkg.sv
// Constants and helpers shared by the FFT datapath blocks.
package fft_bitrev_reorder_pkg;

    localparam int FFT_NB    = 3;
    localparam int FFT_DBW   = 3;
    localparam int FRAME_LEN = 1 << FFT_NB;

    // Mirror the index bits; fft_3 emits bin k at stream position bitrev(k).
    function automatic logic [FFT_NB-1:0] bitrev(input logic [FFT_NB-1:0] a);
        logic [FFT_NB-1:0] r;
        for (int i = 0; i < FFT_NB; i++) begin
            r[i] = a[FFT_NB-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bitrev_reorder_ram.sv
// Ping-pong sample store: two banks selected by the address MSB, synchronous
// write, asynchronous read feeding a registered output.
module fft_bitrev_reorder_ram #(
    parameter int DBW = 3,
    parameter int NB  = 3
) (
    input  logic             clk,
    input  logic             rstx,
    input  logic             we,
    input  logic [NB:0]      waddr,
    input  logic [2*DBW-1:0] wdata,
    input  logic             re,
    input  logic [NB:0]      raddr,
    output logic [2*DBW-1:0] rdata
);

    logic [2*DBW-1:0] mem [2**(NB+1)];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register holds its value whenever no read is issued.
    always_ff @(posedge clk or negedge rstx) begin
        if (!rstx) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Reorders the bit-reversed fft_3 output stream into natural-order frames.
// Optional sticky framing-error flag enabled by FFT_REORDER_CHK_EN.
module fft_bitrev_reorder
    import fft_bitrev_reorder_pkg::*;
#(
    parameter int DBW = FFT_DBW
) (
    input  logic             clk,
    input  logic             rstx,
    input  logic             clear,
    input  logic             din_vld,
    input  logic [2*DBW-1:0] din,
    output logic             dout_vld,
    output logic             dout_sof,
    output logic [2*DBW-1:0] dout
`ifdef FFT_REORDER_CHK_EN
    ,
    output logic             err
`endif
);

    localparam int NB = FFT_NB;

    logic [NB-1:0] wcnt;
    logic [NB-1:0] rcnt;
    logic          wbank;
    logic          rbank;
    logic          rd_act;
    logic          frame_done;
    logic          we;
    logic          re;

    assign frame_done = din_vld && (wcnt == '1);
    assign we         = din_vld && !clear;
    assign re         = rd_act && !clear;

    fft_bitrev_reorder_ram #(
        .DBW (DBW),
        .NB  (NB)
    ) u_ram (
        .clk   (clk),
        .rstx  (rstx),
        .we    (we),
        .waddr ({wbank, bitrev(wcnt)}),
        .wdata (din),
        .re    (re),
        .raddr ({rbank, rcnt}),
        .rdata (dout)
    );

    // Idle = !rd_act, Read = rd_act; a completing frame restarts the reader
    // even on its last cycle, which keeps continuous input gapless.
    always_ff @(posedge clk or negedge rstx) begin
        if (!rstx) begin
            wcnt     <= '0;
            wbank    <= 1'b0;
            rcnt     <= '0;
            rbank    <= 1'b0;
            rd_act   <= 1'b0;
            dout_vld <= 1'b0;
            dout_sof <= 1'b0;
        end else if (clear) begin
            wcnt     <= '0;
            wbank    <= 1'b0;
            rcnt     <= '0;
            rbank    <= 1'b0;
            rd_act   <= 1'b0;
            dout_vld <= 1'b0;
            dout_sof <= 1'b0;
        end else begin
            dout_vld <= rd_act;
            dout_sof <= rd_act && (rcnt == '0);
            if (din_vld) begin
                wcnt <= wcnt + 1'b1;
                if (frame_done) begin
                    wbank <= ~wbank;
                end
            end
            if (rd_act) begin
                rcnt <= rcnt + 1'b1;
                if (rcnt == '1) begin
                    rd_act <= 1'b0;
                end
            end
            if (frame_done) begin
                rbank  <= wbank;
                rd_act <= 1'b1;
                rcnt   <= '0;
            end
        end
    end

`ifdef FFT_REORDER_CHK_EN
    // A missing sample inside a frame marks the stream as misframed.
    always_ff @(posedge clk or negedge rstx) begin
        if (!rstx) begin
            err <= 1'b0;
        end else if (clear) begin
            err <= 1'b0;
        end else if (!din_vld && (wcnt != '0)) begin
            err <= 1'b1;
        end
    end
`endif

endmodule
